// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: bus owner encoding and the registered command.
package mem_arb_pkg;

  localparam int STARVE_W = 4;
  localparam int ARB_AW   = 8;
  localparam int ARB_DW   = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } mem_cmd_t;

  // An access state whose command is a read produces a return one cycle later.
  function automatic logic is_read_access(input owner_t owner, input mem_cmd_t cmd);
    return (owner != OWN_NONE) && !cmd.we;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the DMA requester has been refused.
module arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q;
  logic [STARVE_W-1:0] cnt_d;

  // Clear wins over increment so a granted or withdrawn DMA always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has fixed priority, DMA is guaranteed progress by a
// starvation counter; accept in N, bus cycle in N+1, read data valid in N+2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic     starve_hit;
  owner_t   state_q, state_d;
  owner_t   rsel_q, rsel_d;
  mem_cmd_t cmd_q, cmd_d;

  // Grants are masked during reset so no command can be accepted into a clearing pipeline.
  assign dma_gnt   = ~RESET & dma_req & (~cpu_req | starve_hit);
  assign cpu_gnt   = ~RESET & cpu_req & ~dma_gnt;
  assign cpu_stall = ~RESET & cpu_req & ~cpu_gnt;

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .CLK   (CLK),
    .RESET (RESET),
    .inc   (dma_req & ~dma_gnt),
    .clr   (dma_gnt | ~dma_req),
    .hit   (starve_hit)
  );

  always_comb begin
    state_d = OWN_NONE;
    cmd_d   = cmd_q;
    if (cpu_gnt) begin
      state_d     = OWN_CPU;
      cmd_d.we    = cpu_we;
      cmd_d.addr  = cpu_addr;
      cmd_d.wdata = cpu_wdata;
    end else if (dma_gnt) begin
      state_d     = OWN_DMA;
      cmd_d.we    = dma_we;
      cmd_d.addr  = dma_addr;
      cmd_d.wdata = dma_wdata;
    end
    rsel_d = is_read_access(state_q, cmd_q) ? state_q : OWN_NONE;
  end

  // The command register only loads on a grant, so the bus address/data hold through IDLE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= OWN_NONE;
      rsel_q  <= OWN_NONE;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      cmd_q   <= cmd_d;
    end
  end

  assign mem_re    = (state_q != OWN_NONE) & ~cmd_q.we;
  assign mem_we    = (state_q != OWN_NONE) &  cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  assign cpu_rvalid = (rsel_q == OWN_CPU);
  assign dma_rvalid = (rsel_q == OWN_DMA);
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port program/data memory between the CPU control/datapath and a DMA/loader requester. Each cycle it arbitrates one access and drives the memory bus for one cycle. It returns read data with a fixed two-cycle latency from acceptance. The CPU has fixed priority. A starvation counter guarantees DMA progress. `cpu_stall` tells the CPU sequencer to hold its state while its access is deferred.

## Interface
- `AW`, 8, address width (matches the PC/SP/IRL width)
- `DW`, 8, data width
- `STARVE_MAX`, 4, consecutive cycles DMA may be refused before it is forced to win (range 1..15)
- `CLK`  in  1  clock; all registers update on the rising edge
- `RESET`  in  1  reset, asynchronous, active-high
- `cpu_req`, `cpu_we`  in  1  CPU request; write when `we`=1
- `cpu_addr`  in  AW  CPU address (PC, SP or IRL, selected upstream)
- `cpu_wdata`  in  DW  CPU write data (AC or PC)
- `cpu_gnt`  out  1  CPU request accepted this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  CPU read data valid
- `cpu_rdata`  out  DW  CPU read data
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`  in  1/1/AW/DW  DMA request, same meaning as the CPU fields
- `dma_gnt`, `dma_rvalid`  out  1  DMA accept / read data valid
- `dma_rdata`  out  DW  DMA read data
- `mem_re`, `mem_we`  out  1  memory read / write strobe (never both high)
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  synchronous memory read data, valid the cycle after `mem_re`

## Operation
**Handshake**
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`=1 in the same cycle.
- At that rising edge the command is accepted. The requester may then present a new command or drop `req`.

**Arbitration** (combinational, every cycle, including during bus cycles)
- `dma_gnt = dma_req & (~cpu_req | starve_cnt == STARVE_MAX)`
- `cpu_gnt = cpu_req & ~dma_gnt`
- At most one grant per cycle.

**Starvation counter** `starve_cnt`, 4 bits
- Increments when `dma_req & ~dma_gnt`, saturating at `STARVE_MAX`.
- Clears to 0 when `dma_gnt` is high or `dma_req` is low.

**Owner FSM** (state = owner of the bus in the current cycle)
- States: `IDLE`, `CPU_ACC`, `DMA_ACC`.
- From any state, next state is `CPU_ACC` if `cpu_gnt`, `DMA_ACC` if `dma_gnt`, otherwise `IDLE`.
- The accepted command is registered into `cmd_we`, `cmd_addr`, `cmd_wdata`.
- In `X_ACC`:
  - `mem_addr = cmd_addr`, `mem_wdata = cmd_wdata`
  - `mem_we = cmd_we`, `mem_re = ~cmd_we`
- In `IDLE`: both strobes are 0, and `mem_addr`/`mem_wdata` hold their last value.

**Read return**
- A one-deep return register `rsel ∈ {none, cpu, dma}` is loaded from a read-type access state.
- The following cycle asserts the selected `rvalid` for exactly one cycle.
- `cpu_rdata = dma_rdata = mem_rdata`; each is meaningful only while its `rvalid` is high.
- Writes produce no `rvalid`.

## Timing
**Reset values**
- State `IDLE`; `starve_cnt`=0; `rsel`=none; `cmd_*`=0.
- `mem_re`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
- Both `rvalid` = 0.
- `gnt`/`stall` follow the inputs combinationally but are forced to 0 while RESET is high.

**Latency and throughput**
- Accept in cycle N, memory access in N+1, `rvalid` in N+2.
- Throughput is one access per cycle. Back-to-back accesses, including CPU→DMA→CPU, need no idle cycle.

**Boundary conditions**
- Simultaneous requests: the CPU wins until DMA has been refused `STARVE_MAX` consecutive cycles. DMA then wins one cycle, `cpu_stall`=1, and the counter clears.
- Read followed immediately by a write to the same address: the read returns the old data (memory order equals grant order).
- RESET asserted mid-access: the bus strobes drop immediately and any pending `rvalid` is discarded (never asserted). The in-flight command is lost, and the requester must re-issue after reset.
- `dma_req` dropped before grant: the counter clears and no access occurs.

## Structure
- Shared package `mem_arb_pkg`:
  - `owner_t` enum (`OWN_NONE`, `OWN_CPU`, `OWN_DMA`), used for both FSM state and `rsel`
  - `STARVE_W`=4 constant
  - `mem_cmd_t` struct {`we`, `addr`, `wdata`}
- One sub-module, `arb_starve_cnt`: saturating counter with `inc`/`clr` inputs and a `hit` (== max) output.
- The top level holds the FSM, the command register and the return register.

## Test plan
- **Idle:** RESET high→low, no requests → `mem_re`=`mem_we`=0 and all `gnt`/`rvalid`=0 for 10 cycles.
- **CPU read:** CPU reads 0x20 with the memory holding 0x5A → `cpu_gnt` in N, `mem_re`=1 with `mem_addr`=0x20 in N+1, `cpu_rvalid`=1 with `cpu_rdata`=0x5A in N+2.
- **Write then read:** DMA writes 0x33 to 0x40, then immediately reads 0x40 → `mem_we` then `mem_re` on consecutive cycles; `dma_rdata`=0x33.
- **Starvation:** `cpu_req` held continuously, `dma_req` asserted, `STARVE_MAX`=4 → DMA granted on the 5th cycle with `cpu_stall`=1 for that cycle; the CPU is granted the next cycle.
- **Interleaving:** alternating CPU reads to 0x10/0x11 and DMA reads to 0x80 → each `rvalid` goes only to the issuing requester with the correct data, with no bubbles.
- **Reset mid-read:** RESET pulsed in the cycle after a CPU read is accepted → `mem_re` drops immediately, no `cpu_rvalid` ever, and the state is `IDLE` after release.
